// File: rtl/memory_access_unit.sv
// Memory-stage sequencer: turns EX/MEM load/store controls into 32-bit req/gnt/rvalid beats
// (one for scalars, LANES for vectors), stalls upstream, and registers results into MEM/WB.
module memory_access_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int VEC_WIDTH  = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RegWriteM,
    input  logic                  MemWriteM,
    input  logic                  MemReadM,
    input  logic                  VectorM,
    input  logic                  PCSrcM,
    input  logic [ADDR_WIDTH-1:0] ALUResultM,
    input  logic [VEC_WIDTH-1:0]  WriteDataM,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  StallM,
    output logic                  RegWriteW,
    output logic                  MemtoRegW,
    output logic                  PCSrcW,
    output logic [ADDR_WIDTH-1:0] ALUOutW,
    output logic [VEC_WIDTH-1:0]  ReadDataW
);
    localparam int BYTES  = DATA_WIDTH / 8;
    localparam int LANES  = VEC_WIDTH / DATA_WIDTH;
    localparam int BEAT_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(BYTES - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;

    state_t                state_q;
    logic [BEAT_W-1:0]     beat_q;
    logic [DATA_WIDTH-1:0] lane_q [LANES];
    logic [DATA_WIDTH-1:0] wlane  [LANES];
    logic [VEC_WIDTH-1:0]  rd_flat;
    logic                  access;
    logic                  is_load;
    logic [BEAT_W-1:0]     last_beat;
    logic [ADDR_WIDTH-1:0] beat_addr;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign wlane[gi] = WriteDataM[gi*DATA_WIDTH +: DATA_WIDTH];
            assign rd_flat[gi*DATA_WIDTH +: DATA_WIDTH] = lane_q[gi];
        end
    endgenerate

    // A simultaneous read+write request is executed as a store.
    assign access    = MemReadM | MemWriteM;
    assign is_load   = MemReadM & ~MemWriteM;
    assign last_beat = VectorM ? BEAT_W'(LANES - 1) : '0;
    assign beat_addr = ALUResultM + ADDR_WIDTH'(beat_q) * ADDR_WIDTH'(BYTES);

    assign mem_req   = (state_q == S_REQ);
    assign mem_we    = mem_req & MemWriteM;
    assign mem_addr  = mem_req ? (beat_addr & ~OFF_MASK) : '0;
    assign mem_wdata = mem_req ? wlane[beat_q] : '0;
    assign StallM    = ((state_q == S_IDLE) & access) | (state_q == S_REQ) | (state_q == S_RESP);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            beat_q    <= '0;
            for (int i = 0; i < LANES; i++) lane_q[i] <= '0;
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
            PCSrcW    <= 1'b0;
            ALUOutW   <= '0;
            ReadDataW <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (access) begin
                        state_q <= S_REQ;
                        beat_q  <= '0;
                        // Cleared so unused lanes of a scalar load read back as zero.
                        for (int i = 0; i < LANES; i++) lane_q[i] <= '0;
                    end
                end
                S_REQ: begin
                    if (mem_gnt) begin
                        if (!MemWriteM) begin
                            state_q <= S_RESP;
                        end else if (beat_q == last_beat) begin
                            state_q <= S_DONE;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                S_RESP: begin
                    if (mem_rvalid) begin
                        lane_q[beat_q] <= mem_rdata;
                        if (beat_q == last_beat) begin
                            state_q <= S_DONE;
                        end else begin
                            beat_q  <= beat_q + 1'b1;
                            state_q <= S_REQ;
                        end
                    end
                end
                S_DONE: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase

            if (!StallM) begin
                RegWriteW <= RegWriteM;
                MemtoRegW <= MemReadM;
                PCSrcW    <= PCSrcM;
                ALUOutW   <= ALUResultM;
                ReadDataW <= ((state_q == S_DONE) && is_load) ? rd_flat : '0;
            end
        end
    end
endmodule

// File: tb/tb_memory_access_unit.sv
// Bench for memory_access_unit: directed vector table, a reset-abort sequence and random ops,
// all checked cycle by cycle against expectations derived from addresses, lanes and beat counts.
module tb_memory_access_unit;
    logic         clk = 1'b0;
    logic         rst;
    logic         RegWriteM, MemWriteM, MemReadM, VectorM, PCSrcM;
    logic [31:0]  ALUResultM;
    logic [127:0] WriteDataM;
    logic         mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0]  mem_addr, mem_wdata, mem_rdata;
    logic         StallM, RegWriteW, MemtoRegW, PCSrcW;
    logic [31:0]  ALUOutW;
    logic [127:0] ReadDataW;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rw, mw, mr, vec, pcs;
        logic [31:0] addr;
        logic [127:0] wdata;
        logic [31:0] rd_base;
        int          gwait;
        int          rwait;
    } op_t;

    typedef struct {
        int              beats;
        logic [3:0][31:0] baddr;
        logic [127:0]    rd;
    } exp_t;

    typedef struct {
        op_t  op;
        exp_t ex;
    } vec_t;

    memory_access_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .VEC_WIDTH(128)) dut (
        .clk(clk), .rst(rst),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemReadM(MemReadM),
        .VectorM(VectorM), .PCSrcM(PCSrcM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .StallM(StallM), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .PCSrcW(PCSrcW),
        .ALUOutW(ALUOutW), .ReadDataW(ReadDataW)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic op_t mk(input logic rw, mw, mr, vec, pcs, input logic [31:0] addr,
                               input logic [127:0] wdata, input logic [31:0] rd_base,
                               input int gwait, input int rwait);
        op_t o;
        o.rw = rw; o.mw = mw; o.mr = mr; o.vec = vec; o.pcs = pcs;
        o.addr = addr; o.wdata = wdata; o.rd_base = rd_base;
        o.gwait = gwait; o.rwait = rwait;
        return o;
    endfunction

    function automatic exp_t mkexp(input int beats, input logic [31:0] a0, a1, a2, a3,
                                   input logic [127:0] rd);
        exp_t e;
        e.beats = beats;
        e.baddr = {a3, a2, a1, a0};
        e.rd = rd;
        return e;
    endfunction

    // Reference: word-aligned addresses stepping by 4 bytes with 32-bit wrap; beat i of a load returns rd_base+i.
    function automatic exp_t model(input op_t o);
        exp_t e;
        logic [31:0] a;
        e.beats = (o.mr || o.mw) ? (o.vec ? 4 : 1) : 0;
        e.baddr = '0;
        e.rd = '0;
        for (int i = 0; i < e.beats; i++) begin
            a = o.addr + 32'(4 * i);
            e.baddr[i] = {a[31:2], 2'b00};
            if (o.mr && !o.mw) e.rd[32*i +: 32] = o.rd_base + 32'(i);
        end
        return e;
    endfunction

    task automatic drive_idle();
        RegWriteM = 0; MemWriteM = 0; MemReadM = 0; VectorM = 0; PCSrcM = 0;
        ALUResultM = '0; WriteDataM = '0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
    endtask

    task automatic do_op(input op_t op, input exp_t ex, input string tag);
        RegWriteM = op.rw; MemWriteM = op.mw; MemReadM = op.mr; VectorM = op.vec;
        PCSrcM = op.pcs; ALUResultM = op.addr; WriteDataM = op.wdata;
        mem_gnt = 0; mem_rvalid = 0;
        #1;
        if (ex.beats == 0) begin
            chk({tag, " alu_stall"}, StallM, 0);
            chk({tag, " alu_req"}, mem_req, 0);
        end else begin
            chk({tag, " idle_stall"}, StallM, 1);
            chk({tag, " idle_req"}, mem_req, 0);
            cycle();
            for (int b = 0; b < ex.beats; b++) begin
                for (int w = 0; w <= op.gwait; w++) begin
                    chk({tag, " req"}, mem_req, 1);
                    chk({tag, " we"}, mem_we, op.mw);
                    chk({tag, " addr"}, mem_addr, ex.baddr[b]);
                    if (op.mw) chk({tag, " wdata"}, mem_wdata, op.wdata[32*b +: 32]);
                    chk({tag, " req_stall"}, StallM, 1);
                    if (w == op.gwait) begin
                        mem_gnt = 1;
                        // rvalid coincident with gnt must be ignored
                        if (!op.mw && $urandom_range(0, 1) == 1) begin
                            mem_rvalid = 1;
                            mem_rdata = 32'hBAD0_0000;
                        end
                    end
                    cycle();
                    mem_gnt = 0; mem_rvalid = 0;
                end
                if (!op.mw) begin
                    for (int w = 0; w <= op.rwait; w++) begin
                        chk({tag, " resp_req"}, mem_req, 0);
                        chk({tag, " resp_stall"}, StallM, 1);
                        if (w == op.rwait) begin
                            mem_rvalid = 1;
                            mem_rdata = op.rd_base + 32'(b);
                        end
                        cycle();
                        mem_rvalid = 0;
                    end
                end
            end
            chk({tag, " done_stall"}, StallM, 0);
            chk({tag, " done_req"}, mem_req, 0);
        end
        cycle();
        chk({tag, " RegWriteW"}, RegWriteW, op.rw);
        chk({tag, " MemtoRegW"}, MemtoRegW, op.mr);
        chk({tag, " PCSrcW"}, PCSrcW, op.pcs);
        chk({tag, " ALUOutW"}, ALUOutW, op.addr);
        chk({tag, " ReadDataW"}, ReadDataW, ex.rd);
        $display("%s: rw=%0b mw=%0b mr=%0b vec=%0b addr=%08h beats=%0d ReadDataW=%032h",
                 tag, op.rw, op.mw, op.mr, op.vec, op.addr, ex.beats, ReadDataW);
    endtask

    vec_t tbl[9];

    initial begin
        op_t  op;
        exp_t ex;

        tbl[0] = '{mk(1,0,0,0,0, 32'h10, '0, '0, 0, 0), mkexp(0, 0, 0, 0, 0, '0)};
        tbl[1] = '{mk(0,1,0,0,0, 32'h100, 128'hDEADBEEF, '0, 2, 0),
                   mkexp(1, 32'h100, 0, 0, 0, '0)};
        tbl[2] = '{mk(1,0,1,1,0, 32'h200, '0, 32'hA, 1, 2),
                   mkexp(4, 32'h200, 32'h204, 32'h208, 32'h20C,
                         128'h0000000D_0000000C_0000000B_0000000A)};
        tbl[3] = '{mk(0,1,0,1,0, 32'hFFFF_FFF8, 128'h44444444_33333333_22222222_11111111, '0, 0, 0),
                   mkexp(4, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4, '0)};
        tbl[4] = '{mk(1,0,1,0,1, 32'h40, '0, 32'h1234_5678, 0, 0),
                   mkexp(1, 32'h40, 0, 0, 0, 128'h1234_5678)};
        tbl[5] = '{mk(0,1,0,0,0, 32'h44, 128'h0000_CAFE, '0, 1, 0),
                   mkexp(1, 32'h44, 0, 0, 0, '0)};
        tbl[6] = '{mk(1,0,1,0,0, 32'h103, '0, 32'h5555_0000, 0, 1),
                   mkexp(1, 32'h100, 0, 0, 0, 128'h5555_0000)};
        tbl[7] = '{mk(1,0,1,1,0, 32'h2, '0, 32'h7000_0000, 0, 0),
                   mkexp(4, 32'h0, 32'h4, 32'h8, 32'hC,
                         128'h70000003_70000002_70000001_70000000)};
        tbl[8] = '{mk(1,1,1,0,1, 32'h80, 128'h0BAD_F00D, 32'h1111, 0, 0),
                   mkexp(1, 32'h80, 0, 0, 0, '0)};

        // Reset dominates: an ALU op presented during reset must not reach WB.
        drive_idle();
        rst = 0;
        RegWriteM = 1; ALUResultM = 32'h55; PCSrcM = 1;
        cycle();
        cycle();
        chk("rst RegWriteW", RegWriteW, 0);
        chk("rst MemtoRegW", MemtoRegW, 0);
        chk("rst PCSrcW", PCSrcW, 0);
        chk("rst ALUOutW", ALUOutW, 0);
        chk("rst ReadDataW", ReadDataW, 0);
        chk("rst mem_req", mem_req, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst StallM", StallM, 0);
        rst = 1;

        for (int i = 0; i < 9; i++) do_op(tbl[i].op, tbl[i].ex, $sformatf("vec%0d", i));

        // Reset during RESP of the second beat of a vector load.
        drive_idle();
        RegWriteM = 1; MemReadM = 1; VectorM = 1; ALUResultM = 32'h300;
        #1;
        cycle();
        mem_gnt = 1; cycle(); mem_gnt = 0;
        mem_rvalid = 1; mem_rdata = 32'h1; cycle(); mem_rvalid = 0;
        mem_gnt = 1; cycle(); mem_gnt = 0;
        chk("abort pre_stall", StallM, 1);
        chk("abort pre_req", mem_req, 0);
        rst = 0;
        drive_idle();
        cycle();
        rst = 1;
        #1;
        chk("abort mem_req", mem_req, 0);
        chk("abort StallM", StallM, 0);
        chk("abort RegWriteW", RegWriteW, 0);
        chk("abort ALUOutW", ALUOutW, 0);
        mem_rvalid = 1; mem_rdata = 32'hFEED_0000;
        cycle();
        mem_rvalid = 0;
        chk("late_rvalid mem_req", mem_req, 0);
        chk("late_rvalid StallM", StallM, 0);
        chk("late_rvalid ReadDataW", ReadDataW, 0);
        chk("late_rvalid MemtoRegW", MemtoRegW, 0);
        $display("abort: reset during vector load RESP, late rvalid ignored");

        op = mk(1,0,1,0,0, 32'h304, '0, 32'h9999_0000, 1, 1);
        do_op(op, model(op), "recover");

        for (int i = 0; i < 40; i++) begin
            int kind;
            kind = $urandom_range(0, 3);
            op = mk(1'($urandom_range(0, 1)), kind[1], kind[0], 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), $urandom,
                    {$urandom, $urandom, $urandom, $urandom}, $urandom,
                    $urandom_range(0, 3), $urandom_range(0, 3));
            do_op(op, model(op), $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
